// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, RV32I load/store width codes and FSM state type.
// Macro LSU_MISALIGN_EN (used by lsu/lsu_align) enables misaligned and split accesses.
package lsu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Access size in bytes for a width code (1, 2 or 4).
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: execute-stage request/response bundle plus the data-RAM port.
// master = execute stage and RAM side, slave = the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_funct3, req_store, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_sel, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_funct3, req_store, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_sel, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane math - store shift/mask, load extract/extend, split detect.
// Works on a 64-bit two-word window; split output exists only with LSU_MISALIGN_EN.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          off_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [2*DATA_W-1:0] rwin_i,
  output logic [2*DATA_W-1:0] wwin_o,
  output logic [2*SEL_W-1:0]  mask_o,
  output logic [DATA_W-1:0]   rdata_o
`ifdef LSU_MISALIGN_EN
  ,
  output logic                split_o
`endif
);

  logic [2:0]        size;
  logic [5:0]        sh;
  logic [DATA_W-1:0] shifted;

  // Position store data/mask by byte offset and pull load bytes down to bit 0.
  always_comb begin
    size    = f3_size(funct3_i);
    sh      = {1'b0, off_i, 3'b000};
    wwin_o  = {{DATA_W{1'b0}}, wdata_i} << sh;
    mask_o  = ((8'd1 << size) - 8'd1) << off_i;
`ifdef LSU_MISALIGN_EN
    split_o = ({1'b0, off_i} + size) > 3'd4;
`endif
    shifted = 32'(rwin_i >> sh);
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'b0, shifted[7:0]};
      F3_HU:   rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving the data-RAM port; one request per 3 cycles (4 when split).
// Macro LSU_MISALIGN_EN: any byte offset legal, word-crossing accesses split into ACC0+ACC1.
// mem_* depend only on registered state and the latched request, never on req_* directly.
module lsu
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  state_e              state_q, state_d;
  logic [2:0]          f3_q;
  logic                store_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                accept, req_illegal;
  logic [ADDR_W-1:0]   base;
  logic [2*DATA_W-1:0] wwin, rwin;
  logic [2*SEL_W-1:0]  mask;
  logic [DATA_W-1:0]   ld_data;
`ifdef LSU_MISALIGN_EN
  logic                split;
  logic [DATA_W-1:0]   lo_q;
`endif

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign base          = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_EN
  // In ACC1 the low word comes from the capture register, the high word from the RAM.
  assign rwin = (state_q == ACC1) ? {bus.mem_rdata, lo_q} : {{DATA_W{1'b0}}, bus.mem_rdata};
`else
  assign rwin = {{DATA_W{1'b0}}, bus.mem_rdata};
`endif

  lsu_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rwin_i   (rwin),
    .wwin_o   (wwin),
    .mask_o   (mask),
    .rdata_o  (ld_data)
`ifdef LSU_MISALIGN_EN
    ,
    .split_o  (split)
`endif
  );

  // Classify the incoming request: unknown width codes, unsigned stores, misalignment.
  always_comb begin
    req_illegal = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = bus.req_store;
      default:          req_illegal = 1'b1;
    endcase
`ifndef LSU_MISALIGN_EN
    if ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) req_illegal = 1'b1;
    if ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0)) req_illegal = 1'b1;
`endif
  end

  // Next state and the response registers, loaded on the cycle that enters RESP.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_illegal) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        state_d    = RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = store_q ? '0 : ld_data;
`ifdef LSU_MISALIGN_EN
        if (split) begin
          state_d    = ACC1;
          rsp_err_d  = rsp_err_q;
          rsp_data_d = rsp_data_q;
        end
`endif
      end
      ACC1: begin
        state_d    = RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = store_q ? '0 : ld_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset; reset abandons any access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Latch the request on accept; it stays stable for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q    <= bus.req_funct3;
      store_q <= bus.req_store;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

`ifdef LSU_MISALIGN_EN
  // Capture the low word at the end of ACC0 for use during ACC1.
  always_ff @(posedge clk) begin
    if (state_q == ACC0) lo_q <= bus.mem_rdata;
  end
`endif

  // Drive the RAM port from state and latched request; quiet outside access cycles.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_sel   = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    case (state_q)
      ACC0: begin
        bus.mem_addr  = base;
        bus.mem_sel   = mask[3:0];
        bus.mem_wdata = store_q ? wwin[31:0] : '0;
        bus.mem_we    = store_q;
      end
      ACC1: begin
        bus.mem_addr  = base + ADDR_W'(4);
        bus.mem_sel   = mask[7:4];
        bus.mem_wdata = store_q ? wwin[63:32] : '0;
        bus.mem_we    = store_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and random requests against a byte-addressed reference memory.
// Expected lanes, timing and load results come from byte-level rules, not window shifts.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM seen by the DUT (256 bytes, address bits above 7 alias) and the reference copy.
  logic [7:0]  ram     [256];
  logic [7:0]  ref_mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_word;
  logic [7:0]  ra;

  int n_chk  = 0;
  int n_fail = 0;

  always_comb begin
    ra = bus.mem_addr[7:0];
    bus.mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
  end

  always @(posedge clk) begin
    if (bd_we) begin
      for (int j = 0; j < 4; j++) ram[bd_addr + 8'(j)] <= bd_word[8*j +: 8];
    end else if (bus.mem_we) begin
      for (int j = 0; j < 4; j++)
        if (bus.mem_sel[j]) ram[bus.mem_addr[7:0] + 8'(j)] <= bus.mem_wdata[8*j +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backdoor word write into both RAM and reference (one cycle).
  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    bd_we   = 1'b1;
    bd_addr = {a[7:2], 2'b00};
    bd_word = w;
    for (int j = 0; j < 4; j++) ref_mem[bd_addr + 8'(j)] = w[8*j +: 8];
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [2:0] f3, input logic st, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && (f3 == F3_BU || f3 == F3_HU)) return 1'b1;
`ifndef LSU_MISALIGN_EN
    if ((a & 32'(size_of(f3) - 1)) != 32'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Little-endian byte gather from the reference memory, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
    if (f3 == F3_B && v[7])  v[31:8]  = '1;
    if (f3 == F3_H && v[15]) v[31:16] = '1;
    return v;
  endfunction

  // One request from IDLE through the first IDLE cycle after RESP, checked cycle by cycle.
  task automatic run_req(input logic [2:0] f3, input logic st, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] o_data, output logic o_err,
                         output logic [31:0] o_addr0, output logic [3:0] o_sel0,
                         output logic [31:0] o_wd0);
    int sz, off, nacc, rel;
    logic ill;
    logic [31:0] exp_data, ea, ew;
    logic [3:0] es;
    sz       = size_of(f3);
    off      = int'(a[1:0]);
    ill      = model_illegal(f3, st, a);
    nacc     = ill ? 0 : ((off + sz > 4) ? 2 : 1);
    exp_data = (ill || st) ? 32'd0 : model_load(f3, a);
    o_addr0  = 32'd0;
    o_sel0   = 4'd0;
    o_wd0    = 32'd0;

    chk("idle_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_store  = st;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    chk("idle_mem_addr", bus.mem_addr, 32'd0);
    chk("idle_mem_ctl", {27'b0, bus.mem_we, bus.mem_sel}, 32'd0);
    chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    // Scramble inputs: they must be ignored outside IDLE.
    bus.req_funct3 = 3'($urandom);
    bus.req_store  = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;

    for (int k = 0; k < nacc; k++) begin
      ea = (a & ~32'd3) + 32'(4 * k);
      es = 4'd0;
      ew = 32'd0;
      for (int j = 0; j < 4; j++) begin
        rel = 4 * k + j - off;
        if (rel >= 0 && rel < sz) es[j] = 1'b1;
        if (st && rel >= 0 && rel < 4) ew[8*j +: 8] = wd[8*rel +: 8];
      end
      if (k == 0) begin
        o_addr0 = bus.mem_addr;
        o_sel0  = bus.mem_sel;
        o_wd0   = bus.mem_wdata;
      end
      chk($sformatf("acc%0d_addr", k), bus.mem_addr, ea);
      chk($sformatf("acc%0d_sel", k), {28'b0, bus.mem_sel}, {28'b0, es});
      chk($sformatf("acc%0d_wdata", k), bus.mem_wdata, ew);
      chk($sformatf("acc%0d_we", k), {31'b0, bus.mem_we}, {31'b0, st});
      chk($sformatf("acc%0d_busy", k), {30'b0, bus.rsp_valid, bus.req_ready}, 32'd0);
      @(negedge clk);
    end

    bus.req_valid = 1'b0;
    chk("resp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("resp_err", {31'b0, bus.rsp_err}, {31'b0, ill});
    chk("resp_data", bus.rsp_data, exp_data);
    chk("resp_mem_quiet", {27'b0, bus.mem_we, bus.mem_sel}, 32'd0);
    chk("resp_ready", {31'b0, bus.req_ready}, 32'd0);
    o_data = bus.rsp_data;
    o_err  = bus.rsp_err;
    @(negedge clk);
    chk("post_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("post_hold_data", bus.rsp_data, exp_data);
    chk("post_hold_err", {31'b0, bus.rsp_err}, {31'b0, ill});

    if (st && !ill)
      for (int i = 0; i < sz; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] d, a0, w0, ra_, rw;
    logic [3:0]  s0;
    logic [2:0]  rf;
    logic        e, rs;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_store  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bd_we          = 1'b0;
    bd_addr        = 8'd0;
    bd_word        = 32'd0;

    @(negedge clk);
    for (int i = 0; i < 64; i++) poke(32'(4 * i), $urandom);

    // Reset values.
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_ctl", {27'b0, bus.mem_we, bus.mem_sel}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word store.
    run_req(F3_W, 1'b1, 32'h10, 32'h12345678, d, e, a0, s0, w0);
    chk("sw_addr", a0, 32'h10);
    chk("sw_sel", {28'b0, s0}, 32'hF);
    chk("sw_wdata", w0, 32'h12345678);
    chk("sw_rsp", {e, d[30:0]}, 32'd0);

    // Byte/half loads with sign and zero extension.
    poke(32'h10, 32'h80FF0000);
    run_req(F3_B, 1'b0, 32'h13, 32'd0, d, e, a0, s0, w0);
    chk("lb_13", d, 32'hFFFFFF80);
    run_req(F3_BU, 1'b0, 32'h13, 32'd0, d, e, a0, s0, w0);
    chk("lbu_13", d, 32'h00000080);
    run_req(F3_H, 1'b0, 32'h12, 32'd0, d, e, a0, s0, w0);
    chk("lh_12", d, 32'hFFFF80FF);

    // Halfword store in the upper lanes.
    run_req(F3_H, 1'b1, 32'h06, 32'h0000ABCD, d, e, a0, s0, w0);
    chk("sh_addr", a0, 32'h04);
    chk("sh_sel", {28'b0, s0}, 32'hC);
    chk("sh_wdata", w0, 32'hABCD0000);

    // Word load crossing a word boundary.
    poke(32'h0C, 32'hDDCCBBAA);
    poke(32'h10, 32'h44332211);
    run_req(F3_W, 1'b0, 32'h0E, 32'd0, d, e, a0, s0, w0);
`ifdef LSU_MISALIGN_EN
    chk("lw_split_data", d, 32'h2211DDCC);
    chk("lw_split_acc0", {a0[27:0], s0}, {28'h000000C, 4'hC});
`else
    chk("lw_mis_err", {31'b0, e}, 32'd1);
    chk("lw_mis_data", d, 32'd0);
`endif
    run_req(3'd3, 1'b0, 32'h10, 32'd0, d, e, a0, s0, w0);
    chk("f3_3_err", {31'b0, e}, 32'd1);
    chk("f3_3_data", d, 32'd0);

    // Random traffic, including addresses near the top of the space.
    repeat (150) begin
      rf  = 3'($urandom);
      rs  = 1'($urandom);
      rw  = $urandom;
      ra_ = ($urandom_range(3) == 0) ? {24'hFFFFFF, 8'($urandom)} : {24'h0, 8'($urandom)};
      if ($urandom_range(1) == 1) ra_ = ra_ & ~32'(size_of(rf) - 1);
      if ($urandom_range(4) == 0) begin
        @(negedge clk);
        chk("gap_idle", {30'b0, bus.rsp_valid, bus.mem_we}, 32'd0);
      end
      run_req(rf, rs, ra_, rw, d, e, a0, s0, w0);
    end

    // RAM contents must match the reference after all stores.
    for (int i = 0; i < 64; i++)
      chk($sformatf("ram_word_%0d", i),
          {ram[4*i+3], ram[4*i+2], ram[4*i+1], ram[4*i]},
          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    // Reset in the middle of a store: no response, back to IDLE.
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_store  = 1'b1;
    bus.req_wdata  = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_EN
    bus.req_addr   = 32'h0F;
`else
    bus.req_addr   = 32'h20;
`endif
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
    @(negedge clk);
`endif
    chk("rst_mid_in_access", {31'b0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mid_sel", {28'b0, bus.mem_sel}, 32'd0);
    chk("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_after_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst_after_data", bus.rsp_data, 32'd0);
    end
    run_req(F3_W, 1'b0, 32'h40, 32'd0, d, e, a0, s0, w0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
